// File: rtl/tristate_delay_line_if.sv
// Channel bundle for tristate_delay_line: per-channel data/enable in, tri-state output view out.
// Optional filtered-pulse counter (TDL_FILTER_COUNT_EN) rides along when that macro is defined.
interface tristate_delay_line_if #(
  parameter int N = 4
);
  logic [N-1:0] d;
  logic [N-1:0] en;
  logic [N-1:0] y_val;
  logic [N-1:0] y_oe;
  logic [N-1:0] busy;
`ifdef TDL_FILTER_COUNT_EN
  logic [15:0]  filt_cnt;
`endif

  modport master (
    output d, en,
    input  y_val, y_oe, busy
`ifdef TDL_FILTER_COUNT_EN
    , input filt_cnt
`endif
  );

  modport slave (
    input  d, en,
    output y_val, y_oe, busy
`ifdef TDL_FILTER_COUNT_EN
    , output filt_cnt
`endif
  );
endinterface

// File: rtl/tristate_delay_line.sv
// N-channel inertial delay line with 0/1/Z states; macro TDL_FILTER_COUNT_EN adds filt_cnt.
// Latency: RISE/FALL/min(RISE,FALL) edges by destination; registered outputs, no backpressure.
// Backpressure: none; every edge samples a new target and short pulses are filtered out.
module tristate_delay_line #(
  parameter int N    = 4,
  parameter int DW   = 4,
  parameter int RISE = 4,
  parameter int FALL = 2
) (
  input  logic clk,
  input  logic rst,
  tristate_delay_line_if.slave bus
);
  localparam int TOFF = (RISE < FALL) ? RISE : FALL;

  // State encoding: bit1 = drive enable, bit0 = driven value, so outputs are plain bit slices.
  localparam logic [1:0] S_Z = 2'b00;
  localparam logic [1:0] S_0 = 2'b10;
  localparam logic [1:0] S_1 = 2'b11;

  if (RISE < 1 || RISE > (2**DW) - 1) begin : g_bad_rise
    $error("tristate_delay_line: RISE out of range for DW");
  end
  if (FALL < 1 || FALL > (2**DW) - 1) begin : g_bad_fall
    $error("tristate_delay_line: FALL out of range for DW");
  end

  logic [1:0]    cur  [N];
  logic [1:0]    pend [N];
  logic [DW-1:0] cnt  [N];
  logic [1:0]    tgt  [N];
  logic [DW-1:0] dly  [N];
  logic [N-1:0]  busy_q;
  logic [N-1:0]  cancel;

  function automatic logic [DW-1:0] delay_of(input logic [1:0] dest);
    case (dest)
      S_1:     delay_of = DW'(RISE);
      S_0:     delay_of = DW'(FALL);
      default: delay_of = DW'(TOFF);
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tgt[i]    = !bus.en[i] ? S_Z : (bus.d[i] ? S_1 : S_0);
      dly[i]    = delay_of(tgt[i]);
      cancel[i] = busy_q[i] && (tgt[i] == cur[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < N; i++) begin
        cur[i]  <= S_Z;
        pend[i] <= S_Z;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (busy_q[i] && tgt[i] == pend[i]) begin
          if (cnt[i] == DW'(1)) begin
            cur[i]    <= pend[i];
            busy_q[i] <= 1'b0;
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] - DW'(1);
          end
        end else if (cancel[i]) begin
          // Pulse shorter than its delay: drop it, output never moved.
          busy_q[i] <= 1'b0;
          pend[i]   <= cur[i];
          cnt[i]    <= '0;
        end else if (tgt[i] != cur[i]) begin
          // Fresh start or restart toward a third state; a one-cycle delay commits now.
          pend[i] <= tgt[i];
          if (dly[i] == DW'(1)) begin
            cur[i]    <= tgt[i];
            busy_q[i] <= 1'b0;
            cnt[i]    <= '0;
          end else begin
            busy_q[i] <= 1'b1;
            cnt[i]    <= dly[i] - DW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.y_oe[i]  = cur[i][1];
      bus.y_val[i] = cur[i][0];
    end
  end

  assign bus.busy = busy_q;

`ifdef TDL_FILTER_COUNT_EN
  logic [15:0] filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
    end else if (|cancel && filt_q != 16'hFFFF) begin
      filt_q <= filt_q + 16'd1;
    end
  end

  assign bus.filt_cnt = filt_q;
`endif
endmodule

// File: doc/tristate_delay_line.md
TRISTATE_DELAY_LINE -- requirements
Module: tristate_delay_line

Interface
REQ-001 Parameter N, default 4: number of independent channels, 1..32.
REQ-002 Parameter DW, default 4: delay counter width per channel.
REQ-003 Parameter RISE, default 4: cycles for a transition to 1.
REQ-004 Parameter FALL, default 2: cycles for a transition to 0.
REQ-005 Localparam TOFF SHALL equal min(RISE, FALL): cycles for a transition to Z.
REQ-006 RISE and FALL SHALL each be 1..2**DW-1; out-of-range values SHALL fail elaboration.
REQ-007 clk  input  1  sole clock; all logic on the rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 d  input  N  per-channel data.
REQ-010 en  input  N  per-channel drive enable; 0 selects target Z.
REQ-011 y_val  output  N  registered output value; 0 whenever y_oe=0.
REQ-012 y_oe  output  N  registered drive flag; 0 means the channel is Z.
REQ-013 busy  output  N  high while a channel has a pending transition.

Function
REQ-014 Each channel SHALL operate independently with state cur in {0,1,Z}, pend in {0,1,Z} and a DW-bit counter cnt.
REQ-015 Target t on each edge: Z if en=0, else d.
REQ-016 Transition delay D by destination: to 1 = RISE, to 0 = FALL, to Z = TOFF (Z->0, Z->1 and 0<->1 included).
REQ-017 Idle (busy=0), t!=cur: load pend=t, busy=1; output changes on the edge D-1 cycles later (same edge when D=1), giving an input-to-output latency of D cycles.
REQ-018 Busy, t==pend: count down; on the final count set cur=pend and clear busy on that edge.
REQ-019 Busy, t==cur: cancel with inertial filtering; clear busy; output unchanged; count one filtered pulse.
REQ-020 Busy, t different from both pend and cur: restart, load pend=t with the D for cur->t.
REQ-021 Outputs SHALL follow cur: y_oe=(cur!=Z), y_val=(cur==1).
REQ-022 busy SHALL be low on every cycle where the channel has no pending transition.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 While rst=1 on an edge, every channel SHALL set cur=Z, pend=Z, cnt=0, busy=0, y_oe=0, y_val=0; rst SHALL win over any in-flight transition.
REQ-025 The first target sample after reset SHALL be on the first edge with rst=0.

Configuration
REQ-026 Macro TDL_FILTER_COUNT_EN: when defined, add output filt_cnt (16 bits).
REQ-027 filt_cnt SHALL increment once per edge on which at least one channel cancels (REQ-019), saturate at 0xFFFF, and clear on rst.
REQ-028 When TDL_FILTER_COUNT_EN is undefined, filt_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Defaults, ch0: en=1,d=1 from reset release edge 1 -> y_oe=1,y_val=1 after edge 4; busy high after edges 1-3, low after edge 4.
REQ-030 ch0 driving 1, d=0 sampled edge k -> y_val=0 after edge k+1; then en=0 sampled edge m -> y_oe=0 after edge m+1 (TOFF=2).
REQ-031 ch0 driving 0, d=1 for exactly 2 edges then back to 0 -> y_val never 1; busy cleared on the cancel edge; filt_cnt +1 if enabled.
REQ-032 ch0 at Z, target 1 sampled 2 edges then en=0,d=0 -> cancel (t==cur=Z), no drive; then target 0 -> y_oe=1,y_val=0 after FALL=2 edges.
REQ-033 ch0 mid-count (cur=Z, pend=1) with rst=1 one edge -> all outputs 0 and busy=0 after that edge; a transition restarts with a full RISE delay.
REQ-034 N=4, all channels toggled on the same edge with mixed targets -> each output changes after its own RISE/FALL/TOFF delay, no cross-channel interaction.
